bus_cycle_arbiter: RTL

BUS_CYCLE_ARBITER -- requirements
Module: bus_cycle_arbiter

---
 rtl/bus_arb_pkg.sv | 32 +++
 rtl/bus_arb_picker.sv | 32 +++
 rtl/bus_cycle_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg
// Shared definitions for the bus cycle arbiter: requester count, pointer
// width, default bus widths, the one-hot FSM state encoding and a small
// one-hot-to-index helper.
package bus_arb_pkg;

  localparam int NUM_REQ         = 2;
  localparam int PTR_W           = 1;
  localparam int DEF_ADDR_WIDTH  = 19;
  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_WAIT_STATES = 0;

  typedef enum logic [4:0] {
    ST_IDLE = 5'b00001,
    ST_T1   = 5'b00010,
    ST_T2   = 5'b00100,
    ST_TW   = 5'b01000,
    ST_T3   = 5'b10000
  } state_e;

  // Returns the index of the set bit of a one-hot requester vector
  // (0 when the vector is empty).
  function automatic logic [PTR_W-1:0] onehotToIdx(input logic [NUM_REQ-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = PTR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bus_arb_picker.sv
// bus_arb_picker
// Combinational winner selection. The requester named by ptr_i has the
// highest priority, the others follow in increasing index order (wrapping).
//   req_i    : per-requester request bits
//   ptr_i    : index of the preferred requester
//   winner_o : one-hot winner, all zero when no request is pending
module bus_arb_picker
  import bus_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] winner_o
);

  logic [PTR_W-1:0] idx;

  // Walk from the lowest-priority offset to the highest so that the last
  // match (the preferred requester) overrides earlier ones. The index wraps
  // naturally because NUM_REQ is a power of two.
  always_comb begin
    winner_o = '0;
    idx      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr_i + PTR_W'(k);
      if (req_i[idx]) begin
        winner_o      = '0;
        winner_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_cycle_arbiter.sv
// bus_cycle_arbiter
// Arbitrates two requesters onto a multiplexed-style external bus and runs
// one IDLE -> T1 -> T2 -> [TW...] -> T3 bus cycle per grant.
//   CLK, RESET_N        : clock and asynchronous active-low reset
//   REQ, WRITE          : per-requester request and direction (1 = write)
//   ADDR0/1, WDATA0/1   : per-requester address and write data
//   GNT, DONE           : one-hot grant (T1..T3) and one-cycle T3 pulse
//   RDATA               : data of the last completed read
//   BUSY                : high in every state except IDLE
//   ALE, CS             : address latch enable and chip select (active high)
//   RD, WR              : read / write strobes (active low)
//   ADDRESS, DATA       : bus address and bidirectional bus data
// Macro BUS_ARB_ROUND_ROBIN_EN: when defined, ties go to the requester not
// served last; otherwise requester 0 always wins ties (no pointer register).
module bus_cycle_arbiter
  import bus_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [NUM_REQ-1:0]    REQ,
  input  logic [NUM_REQ-1:0]    WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDR0,
  input  logic [ADDR_WIDTH-1:0] ADDR1,
  input  logic [DATA_WIDTH-1:0] WDATA0,
  input  logic [DATA_WIDTH-1:0] WDATA1,
  output logic [NUM_REQ-1:0]    GNT,
  output logic [NUM_REQ-1:0]    DONE,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  BUSY,
  output logic                  ALE,
  output logic                  CS,
  output logic                  RD,
  output logic                  WR,
  output logic [ADDR_WIDTH-1:0] ADDRESS,
  inout  wire  [DATA_WIDTH-1:0] DATA
);

  localparam logic [2:0] WAIT_CNT = 3'(WAIT_STATES);

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [NUM_REQ-1:0]    gnt_q;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [NUM_REQ-1:0]    winner;
  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      winIdx;
  logic                  strobe;
  logic                  lastStrobe;

`ifdef BUS_ARB_ROUND_ROBIN_EN
  logic [PTR_W-1:0] ptr_q;

  // The pointer names the preferred requester; once a cycle completes the
  // other requester becomes preferred.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ptr_q <= '0;
    end else if (state_q == ST_T3) begin
      ptr_q <= onehotToIdx(gnt_q) + PTR_W'(1);
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  bus_arb_picker u_picker (
    .req_i    (REQ),
    .ptr_i    (ptr),
    .winner_o (winner)
  );

  assign winIdx = onehotToIdx(winner);

  // The counter is loaded on the way into T2 and counts the remaining TW
  // cycles; TW exits once the final wait cycle is reached.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (|REQ) state_d = ST_T1;
      ST_T1: begin
        state_d = ST_T2;
        cnt_d   = WAIT_CNT;
      end
      ST_T2:   state_d = (cnt_q != 3'd0) ? ST_TW : ST_T3;
      ST_TW: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = ST_T3;
      end
      ST_T3:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign strobe     = (state_q == ST_T2) || (state_q == ST_TW);
  assign lastStrobe = ((state_q == ST_T2) && (cnt_q == 3'd0)) ||
                      ((state_q == ST_TW) && (cnt_q <= 3'd1));

  // Transaction attributes are captured only at the IDLE -> T1 edge so
  // requesters are free to change them for the rest of the cycle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if ((state_q == ST_IDLE) && (|REQ)) begin
        gnt_q   <= winner;
        write_q <= WRITE[winIdx];
        addr_q  <= (winIdx == PTR_W'(1)) ? ADDR1 : ADDR0;
        wdata_q <= (winIdx == PTR_W'(1)) ? WDATA1 : WDATA0;
      end else if (state_q == ST_T3) begin
        gnt_q <= '0;
      end
      if (lastStrobe && !write_q) begin
        rdata_q <= DATA;
      end
    end
  end

  assign BUSY    = (state_q != ST_IDLE);
  assign ALE     = (state_q == ST_T1);
  assign CS      = (state_q == ST_T1) || strobe;
  assign RD      = !(strobe && !write_q);
  assign WR      = !(strobe && write_q);
  assign GNT     = gnt_q;
  assign DONE    = (state_q == ST_T3) ? gnt_q : '0;
  assign RDATA   = rdata_q;
  assign ADDRESS = addr_q;
  assign DATA    = !WR ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule
